// File: rtl/vdc_fetch_pkg.sv
// Shared types and constants for the VDC latch fetcher: row phases, request
// tags and glyph-size shift amounts.
package vdc_fetch_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_SCRN = 2'd1,
    R_ATTR = 2'd2
  } row_phase_t;

  typedef enum logic [1:0] {
    TAG_SCRN = 2'd0,
    TAG_ATTR = 2'd1,
    TAG_CHAR = 2'd2
  } req_tag_t;

  localparam int unsigned GLYPH16_SHIFT = 4;
  localparam int unsigned GLYPH32_SHIFT = 5;

  // Char rows taller than 16 scanlines use 32-byte glyphs.
  function automatic logic [2:0] glyph_shift(input logic [4:0] ctv);
    if (ctv > 5'd15) begin
      return 3'(GLYPH32_SHIFT);
    end else begin
      return 3'(GLYPH16_SHIFT);
    end
  endfunction

endpackage

// File: rtl/vdc_fetch_charaddr.sv
// Combinational char/bitmap byte address generator for the charbuf stream.
module vdc_fetch_charaddr
  import vdc_fetch_pkg::*;
(
  input  logic [8:0]  cn,
  input  logic [2:0]  reg_cb,
  input  logic [4:0]  reg_ctv,
  input  logic [4:0]  line,
  input  logic [15:0] bmaddr,
  input  logic [7:0]  k,
  input  logic        reg_text,
  output logic [15:0] addr
);

  logic [15:0] glyph_s;

  // Glyph offset inside the char base, or linear bitmap address.
  always_comb begin
    glyph_s = {7'd0, cn} << glyph_shift(reg_ctv);
    if (reg_text) begin
      addr = bmaddr + {8'd0, k};
    end else begin
      addr = {reg_cb, 13'd0} + glyph_s + {11'd0, line};
    end
  end

endmodule

// File: rtl/vdc_fetch.sv
// VDC latch fetcher: fills scrnbuf/attrbuf for the next row and streams the
// charbuf ring for the current line. VDC_FETCH_STATS_EN adds an underrun counter.
module vdc_fetch
  import vdc_fetch_pkg::*;
#(
  parameter int unsigned S_LATCH_WIDTH = 80,
  parameter int unsigned C_LATCH_WIDTH = 8
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  enable,
  input  logic [7:0]                            reg_hd,
  input  logic [4:0]                            reg_ctv,
  input  logic [2:0]                            reg_cb,
  input  logic                                  reg_text,
  input  logic                                  reg_atr,
  input  logic                                  fetchRow,
  input  logic                                  fetchLine,
  input  logic                                  rowbuf,
  input  logic [7:0]                            col,
  input  logic [4:0]                            line,
  input  logic [15:0]                           nextaddr,
  input  logic [15:0]                           nextattr,
  input  logic [15:0]                           bmaddr,
  output logic [1:0][S_LATCH_WIDTH-1:0][7:0]    scrnbuf,
  output logic [1:0][S_LATCH_WIDTH-1:0][7:0]    attrbuf,
  output logic [C_LATCH_WIDTH-1:0][7:0]         charbuf,
  output logic                                  ram_req,
  output logic [15:0]                           ram_addr,
  input  logic                                  ram_ack,
  input  logic [7:0]                            ram_data,
`ifdef VDC_FETCH_STATS_EN
  input  logic                                  stats_clr,
  output logic [7:0]                            underruns,
`endif
  output logic                                  busy
);

  localparam int unsigned IW = $clog2(S_LATCH_WIDTH + 1);
  localparam int unsigned SW = $clog2(S_LATCH_WIDTH);
  localparam int unsigned CW = $clog2(C_LATCH_WIDTH);

  row_phase_t     row_phase_r;
  logic           row_wb_r;
  logic [15:0]    row_base_r;
  logic [15:0]    attr_base_r;
  logic [IW-1:0]  row_i_r;
  logic [IW-1:0]  row_n_r;
  logic           row_gen_r;

  logic           stream_on_r;
  logic [7:0]     k_r;
  logic [4:0]     line_r;
  logic [15:0]    bmaddr_r;
  logic           char_gen_r;
  logic [7:0]     col_r;

  req_tag_t       req_tag_r;
  logic           req_wb_r;
  logic [IW-1:0]  req_idx_r;
  logic [CW-1:0]  req_slot_r;
  logic           req_gen_r;

  logic           row_start_s;
  logic           line_start_s;
  logic           stream_act_s;
  logic           char_ok_s;
  logic           issue_char_s;
  logic           issue_row_s;
  logic           k_in_s;
  logic [SW-1:0]  kidx_s;
  logic [8:0]     cn_s;
  logic [IW-1:0]  row_n_new_s;
  logic [15:0]    char_addr_s;

  // Start strobes, arbitration and the screen code feeding the glyph address.
  always_comb begin
    row_start_s  = fetchRow & enable;
    line_start_s = fetchLine & enable;
    stream_act_s = stream_on_r & (k_r != reg_hd);
    char_ok_s    = stream_act_s &
                   (({1'b0, k_r} + 9'd8) < ({1'b0, col_r} + 9'(C_LATCH_WIDTH)));
    issue_char_s = 1'b0;
    issue_row_s  = 1'b0;
    if (!ram_req && !row_start_s && !line_start_s) begin
      issue_char_s = char_ok_s;
      issue_row_s  = ~char_ok_s & (row_phase_r != R_IDLE);
    end else begin
      issue_char_s = 1'b0;
      issue_row_s  = 1'b0;
    end
    k_in_s = ({24'd0, k_r} < S_LATCH_WIDTH);
    if (k_in_s) begin
      kidx_s = SW'(k_r);
      cn_s   = {reg_atr & attrbuf[rowbuf][kidx_s][7], scrnbuf[rowbuf][kidx_s]};
    end else begin
      kidx_s = {SW{1'b0}};
      cn_s   = 9'd0;
    end
    if ({24'd0, reg_hd} > S_LATCH_WIDTH) begin
      row_n_new_s = IW'(S_LATCH_WIDTH);
    end else begin
      row_n_new_s = IW'(reg_hd);
    end
  end

  vdc_fetch_charaddr u_charaddr (
    .cn       (cn_s),
    .reg_cb   (reg_cb),
    .reg_ctv  (reg_ctv),
    .line     (line_r),
    .bmaddr   (bmaddr_r),
    .k        (k_r),
    .reg_text (reg_text),
    .addr     (char_addr_s)
  );

  // Row phase sequencer; the generation bit invalidates in-flight row reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_phase_r <= R_IDLE;
      row_wb_r    <= 1'b0;
      row_base_r  <= 16'd0;
      attr_base_r <= 16'd0;
      row_i_r     <= {IW{1'b0}};
      row_n_r     <= {IW{1'b0}};
      row_gen_r   <= 1'b0;
    end else if (row_start_s) begin
      row_wb_r    <= ~rowbuf;
      row_base_r  <= nextaddr;
      attr_base_r <= nextattr;
      row_i_r     <= {IW{1'b0}};
      row_n_r     <= row_n_new_s;
      row_gen_r   <= ~row_gen_r;
      if (row_n_new_s == {IW{1'b0}}) begin
        row_phase_r <= R_IDLE;
      end else if (!reg_text) begin
        row_phase_r <= R_SCRN;
      end else if (reg_atr) begin
        row_phase_r <= R_ATTR;
      end else begin
        row_phase_r <= R_IDLE;
      end
    end else if (issue_row_s) begin
      if (row_i_r + IW'(1) == row_n_r) begin
        row_i_r <= {IW{1'b0}};
        if (row_phase_r == R_SCRN && reg_atr) begin
          row_phase_r <= R_ATTR;
        end else begin
          row_phase_r <= R_IDLE;
        end
      end else begin
        row_i_r <= row_i_r + IW'(1);
      end
    end
  end

  // Char stream position and per-line context.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stream_on_r <= 1'b0;
      k_r         <= 8'd0;
      line_r      <= 5'd0;
      bmaddr_r    <= 16'd0;
      char_gen_r  <= 1'b0;
      col_r       <= 8'd0;
    end else begin
      if (enable) begin
        col_r <= col;
      end
      if (line_start_s) begin
        stream_on_r <= 1'b1;
        k_r         <= 8'd0;
        line_r      <= line;
        bmaddr_r    <= bmaddr;
        char_gen_r  <= ~char_gen_r;
      end else if (issue_char_s) begin
        k_r <= k_r + 8'd1;
      end else if (!stream_act_s) begin
        stream_on_r <= 1'b0;
      end
    end
  end

  // Single-outstanding request: issue, hold until ack, then drop for a cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_req    <= 1'b0;
      ram_addr   <= 16'd0;
      req_tag_r  <= TAG_SCRN;
      req_wb_r   <= 1'b0;
      req_idx_r  <= {IW{1'b0}};
      req_slot_r <= {CW{1'b0}};
      req_gen_r  <= 1'b0;
    end else if (ram_req) begin
      if (ram_ack) begin
        ram_req <= 1'b0;
      end
    end else if (issue_char_s) begin
      ram_req    <= 1'b1;
      ram_addr   <= char_addr_s;
      req_tag_r  <= TAG_CHAR;
      req_slot_r <= k_r[CW-1:0];
      req_gen_r  <= char_gen_r;
    end else if (issue_row_s) begin
      ram_req   <= 1'b1;
      req_wb_r  <= row_wb_r;
      req_idx_r <= row_i_r;
      req_gen_r <= row_gen_r;
      if (row_phase_r == R_SCRN) begin
        ram_addr  <= row_base_r + 16'(row_i_r);
        req_tag_r <= TAG_SCRN;
      end else begin
        ram_addr  <= attr_base_r + 16'(row_i_r);
        req_tag_r <= TAG_ATTR;
      end
    end
  end

  // Latch write-back on ack; stale generations are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scrnbuf <= '0;
      attrbuf <= '0;
      charbuf <= '0;
    end else if (ram_req && ram_ack) begin
      case (req_tag_r)
        TAG_SCRN: if (req_gen_r == row_gen_r) scrnbuf[req_wb_r][req_idx_r] <= ram_data;
        TAG_ATTR: if (req_gen_r == row_gen_r) attrbuf[req_wb_r][req_idx_r] <= ram_data;
        TAG_CHAR: if (req_gen_r == char_gen_r) charbuf[req_slot_r] <= ram_data;
        default:  ;
      endcase
    end
  end

  assign busy = ram_req | (row_phase_r != R_IDLE) | stream_act_s;

`ifdef VDC_FETCH_STATS_EN
  // Saturating count of enable cycles where the display has caught the fetcher.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underruns <= 8'd0;
    end else if (stats_clr) begin
      underruns <= 8'd0;
    end else if (enable && stream_act_s && ({1'b0, col} >= ({1'b0, k_r} + 9'd8)) &&
                 (underruns != 8'hFF)) begin
      underruns <= underruns + 8'd1;
    end
  end
`endif

endmodule
